food_place_ctrl: RTL

Sequencing controller for food (apple) placement in the snake game. On game start or when the head eats the current food, it draws candidate cells from a free-running 16-bit LFSR. It scans the snake body RAM so that food never lands on a body segment, then publishes the committed position to the renderer and the collision comparator. It also keeps the game score.

---
 rtl/food_place_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/food_place_ctrl.sv
// food_place_ctrl: picks a free cell for the apple.
// Random candidates come from the LFSR; each is checked against every body segment
// in the synchronous body RAM before it is committed.
// After MAX_TRIES colliding draws it switches to a raster walk so placement always terminates.
module food_place_ctrl #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_LEN   = 64,
    parameter int MAX_TRIES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         eat,
    input  logic [15:0]                  rnd,
    input  logic [$clog2(MAX_LEN+1)-1:0] snake_len,
    output logic [$clog2(MAX_LEN)-1:0]   body_addr,
    input  logic [9:0]                   body_x,
    input  logic [9:0]                   body_y,
    output logic [9:0]                   food_x,
    output logic [9:0]                   food_y,
    output logic                         food_valid,
    output logic                         placed,
    output logic                         busy,
    output logic                         board_full,
    output logic [15:0]                  score
);

    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int AW    = $clog2(MAX_LEN);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam int FW    = $clog2(CELLS + 1);

    typedef enum logic [1:0] {IDLE, DRAW, SCAN, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [5:0]      cand_x_q, cand_x_d;
    logic [4:0]      cand_y_q, cand_y_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   cnt_q, cnt_d;      // SCAN cycle index; compare index is cnt_q-1
    logic [TW-1:0]   try_q, try_d;
    logic [FW-1:0]   fb_q, fb_d;        // colliding fallback candidates so far
    logic [5:0]      food_x_q, food_x_d;
    logic [4:0]      food_y_q, food_y_d;
    logic            food_valid_q, food_valid_d;
    logic            placed_q, placed_d;
    logic            full_q, full_d;
    logic [15:0]     score_q, score_d;

    logic [5:0]      rnd_x, adv_x;
    logic [4:0]      rnd_y, adv_y;
    logic            rnd_ok, fallback, too_long, len_zero;
    logic            hit, cmp_vld, last_cmp, more_addr;
    logic            unused_rnd;

    assign rnd_x      = rnd[5:0];
    assign rnd_y      = rnd[12:8];
    assign unused_rnd = ^{rnd[15:13], rnd[7:6]};
    assign rnd_ok     = (int'(rnd_x) < GRID_W) && (int'(rnd_y) < GRID_H);
    assign fallback   = (int'(try_q) >= MAX_TRIES);
    assign too_long   = (int'(snake_len) >= CELLS);
    assign len_zero   = (snake_len == '0);
    assign hit        = (body_x == {4'b0, cand_x_q}) && (body_y == {5'b0, cand_y_q});
    assign cmp_vld    = (cnt_q != '0);
    assign last_cmp   = (int'(cnt_q) == int'(snake_len));
    assign more_addr  = (int'(cnt_q) + 1 < int'(snake_len));

    // Raster-order successor of the last candidate, wrapping at the board edges.
    always_comb begin
        adv_x = cand_x_q + 6'd1;
        adv_y = cand_y_q;
        if (int'(cand_x_q) == GRID_W - 1) begin
            adv_x = '0;
            adv_y = (int'(cand_y_q) == GRID_H - 1) ? '0 : cand_y_q + 5'd1;
        end
    end

    // Next-state and datapath updates; start overrides everything else.
    always_comb begin
        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        try_d        = try_q;
        fb_d         = fb_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        placed_d     = 1'b0;
        full_d       = full_q;
        score_d      = score_q;
        if (start) begin
            state_d      = DRAW;
            score_d      = '0;
            full_d       = 1'b0;
            food_valid_d = 1'b0;
            try_d        = '0;
            fb_d         = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eat && food_valid_q) begin
                        state_d      = DRAW;
                        food_valid_d = 1'b0;
                        try_d        = '0;
                        fb_d         = '0;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                    end
                end
                DRAW: begin
                    if (too_long) begin
                        full_d  = 1'b1;
                        try_d   = '0;
                        fb_d    = '0;
                        state_d = IDLE;
                    end else if (fallback || rnd_ok) begin
                        cand_x_d = fallback ? adv_x : rnd_x;
                        cand_y_d = fallback ? adv_y : rnd_y;
                        addr_d   = '0;
                        cnt_d    = '0;
                        state_d  = len_zero ? COMMIT : SCAN;
                    end
                end
                SCAN: begin
                    cnt_d = cnt_q + LW'(1);
                    if (more_addr) addr_d = addr_q + AW'(1);
                    if (cmp_vld && hit) begin
                        state_d = DRAW;
                        if (!fallback) begin
                            try_d = try_q + TW'(1);
                        end else if (int'(fb_q) == CELLS - 1) begin
                            full_d  = 1'b1;
                            try_d   = '0;
                            fb_d    = '0;
                            state_d = IDLE;
                        end else begin
                            fb_d = fb_q + FW'(1);
                        end
                    end else if (cmp_vld && last_cmp) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    placed_d     = 1'b1;
                    try_d        = '0;
                    fb_d         = '0;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            try_q        <= '0;
            fb_q         <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            placed_q     <= 1'b0;
            full_q       <= 1'b0;
            score_q      <= '0;
        end else begin
            state_q      <= state_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            try_q        <= try_d;
            fb_q         <= fb_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            placed_q     <= placed_d;
            full_q       <= full_d;
            score_q      <= score_d;
        end
    end

    assign body_addr  = addr_q;
    assign food_x     = {4'b0, food_x_q};
    assign food_y     = {5'b0, food_y_q};
    assign food_valid = food_valid_q;
    assign placed     = placed_q;
    assign busy       = (state_q != IDLE);
    assign board_full = full_q;
    assign score      = score_q;

endmodule
